// File: rtl/pattern_stream_ctrl_pkg.sv
// Shared types and defaults for the pattern streaming path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pattern_stream_ctrl_pkg;

  // Read-sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARM    = 3'd1,
    ST_STREAM = 3'd2,
    ST_GAP    = 3'd3,
    ST_DONE   = 3'd4
  } pat_state_t;

  // Default geometry, shared with the loader side of the pattern FIFO.
  localparam int DEF_ROWS    = 480;
  localparam int DEF_GAP_CYC = 4;

endpackage

// File: rtl/pattern_stream_ctrl.sv
// Purpose: read sequencer for the pattern output FIFO; one ROWS-word burst per trigger, num_pat times.
// Latency: trig -> stream_en one cycle; done GAP_CYC+1 cycles after the final read.
// Backpressure: fifo_empty stalls a burst in place (no count taken, underflow flagged sticky).
//
// Ports:
//   clk, reset          stream clock, async active-high reset
//   start, abort        begin a sequence (IDLE only) / return to IDLE (highest priority)
//   trig                per-pattern exposure trigger pulse
//   num_pat             patterns per sequence, latched on an accepted start
//   fifo_empty          empty flag of the pattern output FIFO
//   stream_en           FIFO rd_en and sensor stream-enable source
//   busy, done          not-IDLE status / one-cycle completion pulse
//   pat_cnt, row_cnt    patterns completed / words read in the current pattern
//   underflow           sticky: FIFO ran dry mid-burst
//   trig_miss           sticky: trig arrived in STREAM, GAP or DONE
module pattern_stream_ctrl
  import pattern_stream_ctrl_pkg::*;
#(
  parameter int ROWS    = DEF_ROWS,
  parameter int GAP_CYC = DEF_GAP_CYC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic        trig,
  input  logic [31:0] num_pat,
  input  logic        fifo_empty,
  output logic        stream_en,
  output logic        busy,
  output logic        done,
  output logic [31:0] pat_cnt,
  output logic [15:0] row_cnt,
  output logic        underflow,
  output logic        trig_miss
);

  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);
  localparam logic [15:0]   LAST_ROW = 16'(ROWS - 1);

  pat_state_t    state;
  pat_state_t    nxt;
  logic [31:0]   n_lat;
  logic [GW-1:0] gap_cnt;
  logic          rd_fire;
  logic          last_rd;

  // The FIFO pops only when enabled and non-empty; stream_en is high exactly in STREAM.
  assign rd_fire = (state == ST_STREAM) && !fifo_empty;
  assign last_rd = rd_fire && (row_cnt == LAST_ROW);

  always_comb begin
    nxt = state;
    unique case (state)
      ST_IDLE:   if (start) nxt = (num_pat == 32'd0) ? ST_DONE : ST_ARM;
      ST_ARM:    if (trig) nxt = ST_STREAM;
      ST_STREAM: if (last_rd) nxt = ST_GAP;
      ST_GAP:    if (gap_cnt == GAP_LAST) nxt = (pat_cnt == n_lat) ? ST_DONE : ST_ARM;
      ST_DONE:   nxt = ST_IDLE;
      default:   nxt = ST_IDLE;
    endcase
    if (abort) nxt = ST_IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      stream_en <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pat_cnt   <= '0;
      row_cnt   <= '0;
      underflow <= 1'b0;
      trig_miss <= 1'b0;
      n_lat     <= '0;
      gap_cnt   <= '0;
    end else begin
      state <= nxt;
      // Outputs are decoded from the next state so they change in step with it.
      stream_en <= (nxt == ST_STREAM);
      busy      <= (nxt != ST_IDLE);
      done      <= (nxt == ST_DONE);

      // GAP length counter restarts every time GAP is (re)entered.
      if (state == ST_GAP) gap_cnt <= gap_cnt + 1'b1;
      else                 gap_cnt <= '0;

      if (state == ST_IDLE && start && !abort) begin
        n_lat     <= num_pat;
        pat_cnt   <= '0;
        row_cnt   <= '0;
        underflow <= 1'b0;
        trig_miss <= 1'b0;
      end else begin
        // Counters follow the words actually popped, including one popped in an abort cycle.
        if (last_rd) begin
          row_cnt <= '0;
          pat_cnt <= pat_cnt + 32'd1;
        end else if (rd_fire) begin
          row_cnt <= row_cnt + 16'd1;
        end
        if (state == ST_STREAM && fifo_empty) underflow <= 1'b1;
        if (trig && (state == ST_STREAM || state == ST_GAP || state == ST_DONE))
          trig_miss <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pattern_stream_ctrl.sv
// Purpose: self-checking bench for pattern_stream_ctrl with a transaction-level reference.
// Latency: n/a.
// Backpressure: drives random and directed fifo_empty stalls.
module tb_pattern_stream_ctrl;

  localparam int ROWS = 8;
  localparam int GAP  = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic        trig;
  logic [31:0] num_pat;
  logic        fifo_empty;
  logic        stream_en;
  logic        busy;
  logic        done;
  logic [31:0] pat_cnt;
  logic [15:0] row_cnt;
  logic        underflow;
  logic        trig_miss;

  int checks = 0;
  int errors = 0;
  bit uf_exp;
  bit tm_exp;

  pattern_stream_ctrl #(.ROWS(ROWS), .GAP_CYC(GAP)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .trig       (trig),
    .num_pat    (num_pat),
    .fifo_empty (fifo_empty),
    .stream_en  (stream_en),
    .busy       (busy),
    .done       (done),
    .pat_cnt    (pat_cnt),
    .row_cnt    (row_cnt),
    .underflow  (underflow),
    .trig_miss  (trig_miss)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one burst from the cycle after trig. Reference: a pattern needs ROWS pops,
  // each empty cycle adds one enable cycle, row_cnt is reads modulo ROWS.
  task automatic burst(input int p, input int stall_pct, input bit miss,
                       input int stall_at, input int abort_at, output bit aborted);
    int  reads;
    int  en;
    int  stalls;
    int  dir_stalls;
    int  miss_cyc;
    bit  emp;
    reads = 0; en = 0; stalls = 0; dir_stalls = 0;
    aborted = 1'b0;
    miss_cyc = miss ? int'($urandom_range(ROWS - 1, 0)) : -1;
    chk("stream_en_after_trig", {31'd0, stream_en}, 32'd1);
    while (stream_en === 1'b1 && en < 200) begin
      emp = ($urandom_range(99, 0) < stall_pct);
      if (stall_at >= 0 && reads == stall_at && dir_stalls < 3) begin
        emp = 1'b1;
        dir_stalls++;
      end
      fifo_empty = emp;
      trig = (en == miss_cyc);
      if (trig) tm_exp = 1'b1;
      if (abort_at >= 0 && reads == abort_at && !emp) abort = 1'b1;
      tick();
      trig = 1'b0;
      fifo_empty = 1'b0;
      en++;
      if (emp) begin
        stalls++;
        uf_exp = 1'b1;
      end else begin
        reads++;
      end
      if (abort) begin
        abort = 1'b0;
        aborted = 1'b1;
        break;
      end
      chk("row_cnt", {16'd0, row_cnt}, 32'(reads % ROWS));
      chk("underflow_live", {31'd0, underflow}, {31'd0, uf_exp});
      if (reads < ROWS) chk("pat_cnt_in_burst", pat_cnt, 32'(p));
    end
    chk("burst_ended", {31'd0, stream_en}, 32'd0);
    if (!aborted) begin
      chk("burst_len", 32'(en), 32'(ROWS + stalls));
      chk("burst_reads", 32'(reads), 32'(ROWS));
      chk("pat_cnt_after", pat_cnt, 32'(p + 1));
    end
  endtask

  task automatic run_seq(input int n, input int stall_pct, input bit miss, input int stall_at);
    bit ab;
    int w;
    num_pat = 32'(n);
    start = 1'b1;
    tick();
    start = 1'b0;
    num_pat = $urandom;  // must have been latched already
    uf_exp = 1'b0;
    tm_exp = 1'b0;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    chk("pat_cnt_cleared", pat_cnt, 32'd0);
    chk("underflow_cleared", {31'd0, underflow}, 32'd0);
    chk("trig_miss_cleared", {31'd0, trig_miss}, 32'd0);
    for (int p = 0; p < n; p++) begin
      w = int'($urandom_range(3, 0));
      repeat (w) begin
        chk("arm_no_stream", {31'd0, stream_en}, 32'd0);
        tick();
      end
      trig = 1'b1;
      tick();
      trig = 1'b0;
      burst(p, stall_pct, miss, stall_at, -1, ab);
      for (int g = 0; g < GAP; g++) begin
        chk("gap_no_done", {31'd0, done}, 32'd0);
        chk("gap_no_stream", {31'd0, stream_en}, 32'd0);
        chk("gap_busy", {31'd0, busy}, 32'd1);
        if (miss && g == GAP - 1) begin
          trig = 1'b1;
          tm_exp = 1'b1;
        end
        tick();
        trig = 1'b0;
      end
      if (p == n - 1) begin
        chk("done_pulse", {31'd0, done}, 32'd1);
        chk("final_pat_cnt", pat_cnt, 32'(n));
        tick();
        chk("done_one_cycle", {31'd0, done}, 32'd0);
        chk("busy_fall", {31'd0, busy}, 32'd0);
      end else begin
        chk("rearm_no_done", {31'd0, done}, 32'd0);
      end
    end
    chk("seq_trig_miss", {31'd0, trig_miss}, {31'd0, tm_exp});
    chk("seq_underflow", {31'd0, underflow}, {31'd0, uf_exp});
  endtask

  initial begin
    bit ab;
    int dn;
    int en_seen;
    reset = 1'b1; start = 1'b0; abort = 1'b0; trig = 1'b0;
    num_pat = '0; fifo_empty = 1'b0;
    uf_exp = 1'b0; tm_exp = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stream_en", {31'd0, stream_en}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_pat_cnt", pat_cnt, 32'd0);
    chk("rst_row_cnt", {16'd0, row_cnt}, 32'd0);
    chk("rst_underflow", {31'd0, underflow}, 32'd0);
    chk("rst_trig_miss", {31'd0, trig_miss}, 32'd0);
    reset = 1'b0;
    tick();

    // trig in IDLE is ignored and not flagged.
    trig = 1'b1;
    tick();
    trig = 1'b0;
    tick();
    chk("idle_trig_no_miss", {31'd0, trig_miss}, 32'd0);
    chk("idle_trig_no_busy", {31'd0, busy}, 32'd0);

    // Three clean patterns.
    run_seq(3, 0, 1'b0, -1);

    // Zero-pattern sequence: one done pulse, no streaming.
    num_pat = 32'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    dn = 0; en_seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (done === 1'b1) dn++;
      if (stream_en === 1'b1) en_seen++;
      tick();
    end
    chk("zero_done_count", 32'(dn), 32'd1);
    chk("zero_no_stream", 32'(en_seen), 32'd0);
    chk("zero_idle", {31'd0, busy}, 32'd0);

    // Three-cycle stall after read 4: 11 enable cycles, underflow set.
    run_seq(1, 0, 1'b0, 4);

    // Triggers during STREAM and GAP are flagged and ignored.
    run_seq(2, 0, 1'b1, -1);

    // Randomized sequences.
    repeat (4) run_seq(int'($urandom_range(3, 1)), 25, 1'($urandom_range(1, 0)), -1);

    // Abort at read 4 of pattern 2.
    num_pat = 32'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    uf_exp = 1'b0; tm_exp = 1'b0;
    trig = 1'b1;
    tick();
    trig = 1'b0;
    burst(0, 0, 1'b1, -1, -1, ab);
    repeat (GAP) tick();
    trig = 1'b1;
    tick();
    trig = 1'b0;
    burst(1, 0, 1'b0, -1, 3, ab);
    chk("abort_stream_en", {31'd0, stream_en}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_pat_cnt", pat_cnt, 32'd1);
    chk("abort_keeps_miss", {31'd0, trig_miss}, 32'd1);
    dn = 0;
    repeat (GAP + 3) begin
      if (done === 1'b1) dn++;
      tick();
    end
    chk("abort_no_done", 32'(dn), 32'd0);
    num_pat = 32'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_trig_miss", {31'd0, trig_miss}, 32'd0);
    chk("restart_underflow", {31'd0, underflow}, 32'd0);
    chk("restart_pat_cnt", pat_cnt, 32'd0);
    chk("restart_row_cnt", {16'd0, row_cnt}, 32'd0);
    chk("restart_busy", {31'd0, busy}, 32'd1);

    // Asynchronous reset mid-burst, applied between clock edges.
    trig = 1'b1;
    tick();
    trig = 1'b0;
    tick();
    tick();
    chk("pre_reset_stream", {31'd0, stream_en}, 32'd1);
    #3;
    reset = 1'b1;
    #1;
    chk("async_stream_en", {31'd0, stream_en}, 32'd0);
    chk("async_busy", {31'd0, busy}, 32'd0);
    chk("async_row_cnt", {16'd0, row_cnt}, 32'd0);
    chk("async_pat_cnt", pat_cnt, 32'd0);
    tick();
    reset = 1'b0;
    tick();
    chk("post_reset_idle", {31'd0, busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
